// File: rtl/servant_bus_scheduler_pkg.sv
// Shared definitions for the servant bus scheduler.
//   Master indices, FSM state encoding, ibus default byte select and a
//   one-hot to index helper used when recording the last served master.
package servant_bus_scheduler_pkg;

   localparam logic [1:0] MST_IBUS = 2'd0;
   localparam logic [1:0] MST_DBUS = 2'd1;
   localparam logic [1:0] MST_SPI  = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // ibus only issues full-word reads
   localparam logic [3:0] IBUS_SEL = 4'hF;

   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      idx = MST_IBUS;
      if (oh[2])      idx = MST_SPI;
      else if (oh[1]) idx = MST_DBUS;
      return idx;
   endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// Combinational 3-way rotating priority encoder.
//   req_i  : request vector {spi,dbus,ibus}
//   last_i : index of the master served last; search starts at last_i+1 (mod 3)
//   gnt_o  : one-hot winner, 0 when nothing is requested
module servant_rr_pick
   import servant_bus_scheduler_pkg::*;
(
   input  logic [2:0] req_i,
   input  logic [1:0] last_i,
   output logic [2:0] gnt_o
);

   always_comb begin
      gnt_o = 3'b000;
      case (last_i)
         MST_IBUS: begin
            if (req_i[1])      gnt_o = 3'b010;
            else if (req_i[2]) gnt_o = 3'b100;
            else if (req_i[0]) gnt_o = 3'b001;
         end
         MST_DBUS: begin
            if (req_i[2])      gnt_o = 3'b100;
            else if (req_i[0]) gnt_o = 3'b001;
            else if (req_i[1]) gnt_o = 3'b010;
         end
         default: begin
            if (req_i[0])      gnt_o = 3'b001;
            else if (req_i[1]) gnt_o = 3'b010;
            else if (req_i[2]) gnt_o = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/servant_bus_scheduler.sv
// Round-robin scheduler sharing the servant Wishbone port between the CPU
// ibus, CPU dbus and SPI loader. One transaction at a time, grant locked
// until ack, abort or watchdog release.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_wb_cpu_ibus_*        : ibus request (read-only), o_wb_cpu_ibus_* response
//   i_wb_cpu_dbus_*        : dbus request, o_wb_cpu_dbus_* response
//   i_wb_cpu_spi_*         : SPI loader request, o_wb_cpu_spi_* response
//   o_wb_cpu_*, i_wb_cpu_* : shared bus towards memory/peripheral mux
//   o_grant                : one-hot owner {spi,dbus,ibus}, 0 when idle
//   o_timeout              : 1-cycle pulse on a watchdog release
//
//   state   | meaning
//   ST_IDLE | no owner; arbitrate among pending cyc requests
//   ST_BUSY | owner granted; bus muxed from owner until ack/abort/timeout
module servant_bus_scheduler
   import servant_bus_scheduler_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_cpu_ibus_adr,
   input  logic        i_wb_cpu_ibus_cyc,
   output logic [31:0] o_wb_cpu_ibus_rdt,
   output logic        o_wb_cpu_ibus_ack,
   input  logic [31:0] i_wb_cpu_dbus_adr,
   input  logic [31:0] i_wb_cpu_dbus_dat,
   input  logic [3:0]  i_wb_cpu_dbus_sel,
   input  logic        i_wb_cpu_dbus_we,
   input  logic        i_wb_cpu_dbus_cyc,
   output logic [31:0] o_wb_cpu_dbus_rdt,
   output logic        o_wb_cpu_dbus_ack,
   input  logic [31:0] i_wb_cpu_spi_adr,
   input  logic [31:0] i_wb_cpu_spi_dat,
   input  logic [3:0]  i_wb_cpu_spi_sel,
   input  logic        i_wb_cpu_spi_we,
   input  logic        i_wb_cpu_spi_cyc,
   output logic [31:0] o_wb_cpu_spi_rdt,
   output logic        o_wb_cpu_spi_ack,
   output logic [31:0] o_wb_cpu_adr,
   output logic [31:0] o_wb_cpu_dat,
   output logic [3:0]  o_wb_cpu_sel,
   output logic        o_wb_cpu_we,
   output logic        o_wb_cpu_cyc,
   input  logic [31:0] i_wb_cpu_rdt,
   input  logic        i_wb_cpu_ack,
   output logic [2:0]  o_grant,
   output logic        o_timeout
);

   localparam bit            WD_EN  = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [2:0]      grant_q, grant_d;
   logic [1:0]      last_q, last_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   logic [2:0] req;
   logic [2:0] pick_gnt;
   logic       busy;
   logic       own_cyc;
   logic       to_fire;
   logic       ack_any;
   logic [31:0] rdt_fwd;

   assign req  = {i_wb_cpu_spi_cyc, i_wb_cpu_dbus_cyc, i_wb_cpu_ibus_cyc};
   assign busy = (state_q == ST_BUSY);
   assign own_cyc = |(grant_q & req);

   // A real ack beats the watchdog; a dropped cyc counts as abort, not timeout.
   assign to_fire = WD_EN && busy && own_cyc && !i_wb_cpu_ack && (cnt_q == TO_LAST);
   assign ack_any = busy && (i_wb_cpu_ack || to_fire);
   assign rdt_fwd = to_fire ? 32'h0 : i_wb_cpu_rdt;

   servant_rr_pick u_pick (
      .req_i  (req),
      .last_i (last_q),
      .gnt_o  (pick_gnt)
   );

   assign o_wb_cpu_ibus_ack = ack_any & grant_q[0];
   assign o_wb_cpu_dbus_ack = ack_any & grant_q[1];
   assign o_wb_cpu_spi_ack  = ack_any & grant_q[2];
   assign o_wb_cpu_ibus_rdt = rdt_fwd;
   assign o_wb_cpu_dbus_rdt = rdt_fwd;
   assign o_wb_cpu_spi_rdt  = rdt_fwd;
   assign o_grant   = grant_q;
   assign o_timeout = to_fire;
   assign o_wb_cpu_cyc = busy & own_cyc & ~to_fire;

   // grant_q is zero outside BUSY, so the shared bus idles at all-zero.
   always_comb begin
      o_wb_cpu_adr = 32'h0;
      o_wb_cpu_dat = 32'h0;
      o_wb_cpu_sel = 4'h0;
      o_wb_cpu_we  = 1'b0;
      if (grant_q[0]) begin
         o_wb_cpu_adr = i_wb_cpu_ibus_adr;
         o_wb_cpu_sel = IBUS_SEL;
      end else if (grant_q[1]) begin
         o_wb_cpu_adr = i_wb_cpu_dbus_adr;
         o_wb_cpu_dat = i_wb_cpu_dbus_dat;
         o_wb_cpu_sel = i_wb_cpu_dbus_sel;
         o_wb_cpu_we  = i_wb_cpu_dbus_we;
      end else if (grant_q[2]) begin
         o_wb_cpu_adr = i_wb_cpu_spi_adr;
         o_wb_cpu_dat = i_wb_cpu_spi_dat;
         o_wb_cpu_sel = i_wb_cpu_spi_sel;
         o_wb_cpu_we  = i_wb_cpu_spi_we;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (|req) begin
               grant_d = pick_gnt;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_wb_cpu_ack || !own_cyc || to_fire) begin
               state_d = ST_IDLE;
               last_d  = onehot_to_idx(grant_q);
               grant_d = 3'b000;
               cnt_d   = '0;
            end else if (WD_EN && (cnt_q != '1)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= 3'b000;
         last_q  <= MST_IBUS;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_servant_bus_scheduler.sv
// Directed bench for servant_bus_scheduler with an 8-cycle watchdog.
module tb_servant_bus_scheduler;

   logic        clk;
   logic        rst;
   logic [31:0] ibus_adr;
   logic        ibus_cyc;
   logic [31:0] ibus_rdt;
   logic        ibus_ack;
   logic [31:0] dbus_adr, dbus_dat;
   logic [3:0]  dbus_sel;
   logic        dbus_we, dbus_cyc;
   logic [31:0] dbus_rdt;
   logic        dbus_ack;
   logic [31:0] spi_adr, spi_dat;
   logic [3:0]  spi_sel;
   logic        spi_we, spi_cyc;
   logic [31:0] spi_rdt;
   logic        spi_ack;
   logic [31:0] bus_adr, bus_dat;
   logic [3:0]  bus_sel;
   logic        bus_we, bus_cyc;
   logic [31:0] bus_rdt;
   logic        bus_ack;
   logic [2:0]  grant;
   logic        tout;

   int n_cmp = 0;
   int n_err = 0;

   servant_bus_scheduler #(.TIMEOUT(8), .TO_W(8)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_wb_cpu_ibus_adr (ibus_adr),
      .i_wb_cpu_ibus_cyc (ibus_cyc),
      .o_wb_cpu_ibus_rdt (ibus_rdt),
      .o_wb_cpu_ibus_ack (ibus_ack),
      .i_wb_cpu_dbus_adr (dbus_adr),
      .i_wb_cpu_dbus_dat (dbus_dat),
      .i_wb_cpu_dbus_sel (dbus_sel),
      .i_wb_cpu_dbus_we  (dbus_we),
      .i_wb_cpu_dbus_cyc (dbus_cyc),
      .o_wb_cpu_dbus_rdt (dbus_rdt),
      .o_wb_cpu_dbus_ack (dbus_ack),
      .i_wb_cpu_spi_adr  (spi_adr),
      .i_wb_cpu_spi_dat  (spi_dat),
      .i_wb_cpu_spi_sel  (spi_sel),
      .i_wb_cpu_spi_we   (spi_we),
      .i_wb_cpu_spi_cyc  (spi_cyc),
      .o_wb_cpu_spi_rdt  (spi_rdt),
      .o_wb_cpu_spi_ack  (spi_ack),
      .o_wb_cpu_adr      (bus_adr),
      .o_wb_cpu_dat      (bus_dat),
      .o_wb_cpu_sel      (bus_sel),
      .o_wb_cpu_we       (bus_we),
      .o_wb_cpu_cyc      (bus_cyc),
      .i_wb_cpu_rdt      (bus_rdt),
      .i_wb_cpu_ack      (bus_ack),
      .o_grant           (grant),
      .o_timeout         (tout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] rr_exp [4];
   logic [2:0] acks;

   initial begin
      rst = 1'b1;
      ibus_adr = '0; ibus_cyc = 1'b0;
      dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
      spi_adr = '0; spi_dat = '0; spi_sel = '0; spi_we = 1'b0; spi_cyc = 1'b0;
      bus_rdt = '0; bus_ack = 1'b0;
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

      // reset state
      tick(); tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_cyc", 32'(bus_cyc), 32'h0);
      chk("rst_we", 32'(bus_we), 32'h0);
      chk("rst_ibus_ack", 32'(ibus_ack), 32'h0);
      chk("rst_timeout", 32'(tout), 32'h0);
      rst = 1'b0;

      // 1: ibus alone, slave acks 2 cycles after cyc
      ibus_cyc = 1'b1; ibus_adr = 32'h40; #1;
      chk("t1_idle_grant", 32'(grant), 32'h0);
      chk("t1_idle_cyc", 32'(bus_cyc), 32'h0);
      tick();
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_cyc", 32'(bus_cyc), 32'h1);
      chk("t1_adr", bus_adr, 32'h40);
      chk("t1_sel", 32'(bus_sel), 32'hF);
      chk("t1_dat", bus_dat, 32'h0);
      chk("t1_we", 32'(bus_we), 32'h0);
      chk("t1_early_ack", 32'(ibus_ack), 32'h0);
      tick();
      bus_ack = 1'b1; bus_rdt = 32'hDEADBEEF; #1;
      chk("t1_ibus_ack", 32'(ibus_ack), 32'h1);
      chk("t1_ibus_rdt", ibus_rdt, 32'hDEADBEEF);
      chk("t1_dbus_ack", 32'(dbus_ack), 32'h0);
      chk("t1_spi_ack", 32'(spi_ack), 32'h0);
      chk("t1_timeout", 32'(tout), 32'h0);
      tick();
      bus_ack = 1'b0; ibus_cyc = 1'b0; #1;
      chk("t1_release", 32'(grant), 32'h0);
      chk("t1_ack_after", 32'(ibus_ack), 32'h0);

      // 3: dbus write; ibus raised mid-transfer waits
      dbus_adr = 32'h100; dbus_dat = 32'h12345678; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
      tick();
      chk("t3_grant", 32'(grant), 32'h2);
      chk("t3_adr", bus_adr, 32'h100);
      chk("t3_dat", bus_dat, 32'h12345678);
      chk("t3_sel", 32'(bus_sel), 32'hF);
      chk("t3_we", 32'(bus_we), 32'h1);
      chk("t3_cyc", 32'(bus_cyc), 32'h1);
      ibus_cyc = 1'b1; ibus_adr = 32'h80; #1;
      chk("t3_locked", 32'(grant), 32'h2);
      chk("t3_locked_adr", bus_adr, 32'h100);
      chk("t3_ibus_wait", 32'(ibus_ack), 32'h0);
      tick();
      bus_ack = 1'b1; bus_rdt = 32'hCAFEF00D; #1;
      chk("t3_dbus_ack", 32'(dbus_ack), 32'h1);
      chk("t3_dbus_rdt", dbus_rdt, 32'hCAFEF00D);
      chk("t3_ibus_noack", 32'(ibus_ack), 32'h0);
      tick();
      bus_ack = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0; #1;
      chk("t3_gap_grant", 32'(grant), 32'h0);
      chk("t3_gap_cyc", 32'(bus_cyc), 32'h0);
      tick();
      chk("t3_ibus_grant", 32'(grant), 32'h1);
      chk("t3_ibus_adr", bus_adr, 32'h80);
      bus_ack = 1'b1; bus_rdt = 32'h12; #1;
      chk("t3_ibus_ack", 32'(ibus_ack), 32'h1);
      tick();
      bus_ack = 1'b0; ibus_cyc = 1'b0; #1;

      // 4: watchdog after 8 BUSY cycles, then next requester
      dbus_adr = 32'h200; dbus_we = 1'b0; dbus_cyc = 1'b1;
      spi_adr = 32'h300; spi_dat = 32'h77; spi_sel = 4'h3; spi_we = 1'b1; spi_cyc = 1'b1;
      bus_rdt = 32'h55AA55AA; #1;
      tick();
      chk("t4_grant", 32'(grant), 32'h2);
      for (int i = 0; i < 7; i++) begin
         chk("t4_no_timeout", 32'(tout), 32'h0);
         chk("t4_no_ack", 32'(dbus_ack), 32'h0);
         tick();
      end
      chk("t4_timeout", 32'(tout), 32'h1);
      chk("t4_synth_ack", 32'(dbus_ack), 32'h1);
      chk("t4_rdt_zero", dbus_rdt, 32'h0);
      chk("t4_cyc_drop", 32'(bus_cyc), 32'h0);
      chk("t4_spi_noack", 32'(spi_ack), 32'h0);
      tick();
      dbus_cyc = 1'b0; #1;
      chk("t4_pulse_end", 32'(tout), 32'h0);
      chk("t4_idle", 32'(grant), 32'h0);
      tick();
      chk("t4_next_grant", 32'(grant), 32'h4);
      chk("t4_spi_adr", bus_adr, 32'h300);
      chk("t4_spi_we", 32'(bus_we), 32'h1);

      // 5: reset during BUSY
      rst = 1'b1;
      tick();
      chk("t5_cyc", 32'(bus_cyc), 32'h0);
      chk("t5_grant", 32'(grant), 32'h0);
      chk("t5_spi_ack", 32'(spi_ack), 32'h0);
      rst = 1'b0; spi_cyc = 1'b0; ibus_cyc = 1'b1; ibus_adr = 32'h44; #1;
      chk("t5_idle_grant", 32'(grant), 32'h0);
      tick();
      chk("t5_ibus_first", 32'(grant), 32'h1);

      // 6a: ack coincides with watchdog expiry
      for (int i = 0; i < 7; i++) begin
         chk("t6_no_timeout", 32'(tout), 32'h0);
         tick();
      end
      bus_ack = 1'b1; bus_rdt = 32'h0BADF00D; #1;
      chk("t6_real_ack", 32'(ibus_ack), 32'h1);
      chk("t6_real_rdt", ibus_rdt, 32'h0BADF00D);
      chk("t6_no_pulse", 32'(tout), 32'h0);
      chk("t6_cyc_kept", 32'(bus_cyc), 32'h1);
      tick();
      bus_ack = 1'b0; ibus_cyc = 1'b0; spi_cyc = 1'b1; spi_adr = 32'h304; #1;
      chk("t6_idle", 32'(grant), 32'h0);

      // 6b: abort
      tick();
      chk("t6_spi_grant", 32'(grant), 32'h4);
      spi_cyc = 1'b0; #1;
      chk("t6_abort_cyc", 32'(bus_cyc), 32'h0);
      chk("t6_abort_ack", 32'(spi_ack), 32'h0);
      tick();
      chk("t6_abort_idle", 32'(grant), 32'h0);
      chk("t6_abort_noack", 32'(spi_ack), 32'h0);

      // 2: all three held, auto-ack; ack while idle is ignored
      ibus_cyc = 1'b1; dbus_cyc = 1'b1; spi_cyc = 1'b1; bus_ack = 1'b1; bus_rdt = 32'h1; #1;
      acks = {spi_ack, dbus_ack, ibus_ack};
      chk("t2_idle_ack", 32'(acks), 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         bus_ack = 1'b1; #1;
         acks = {spi_ack, dbus_ack, ibus_ack};
         chk("t2_rr_grant", 32'(grant), 32'(rr_exp[k]));
         chk("t2_rr_ack", 32'(acks), 32'(rr_exp[k]));
         tick();
         bus_ack = 1'b0; #1;
         chk("t2_gap", 32'(grant), 32'h0);
         chk("t2_gap_cyc", 32'(bus_cyc), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
